seq_chunk_adder: RTL and testbench
==================================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter CHUNK, default 8, bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operands and mode are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept a new operation.
REQ-007 SHALL have port a  input  WIDTH  operand A, two's complement.
REQ-008 SHALL have port b  input  WIDTH  operand B, two's complement.
REQ-009 SHALL have port sub  input  1  0 = A+B, 1 = A-B.
REQ-010 SHALL have port out_valid  output  1  result fields are valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port sum  output  WIDTH  result.
REQ-013 SHALL have port carry_out  output  1  raw carry out of the MSB.
REQ-014 SHALL have port overflow  output  1  signed two's-complement overflow.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid&in_ready SHALL capture a, b_eff = sub ? ~b : b, carry register = sub, chunk index = 0, and go to RUN.
REQ-017 RUN: each cycle SHALL add chunk[idx] of captured A and b_eff plus carry register, write the CHUNK-bit result into sum[idx], update carry register, increment idx.
REQ-018 RUN SHALL last exactly NCHUNK cycles, then go to DONE; out_valid SHALL assert NCHUNK cycles after the accept edge.
REQ-019 DONE: out_valid=1; sum, carry_out, overflow SHALL be held stable until out_valid&out_ready, then go to IDLE.
REQ-020 in_ready SHALL be 0 in RUN and DONE; a new operation SHALL NOT be accepted in the cycle the result is consumed (throughput NCHUNK+2 cycles per operation with out_ready held at 1).
REQ-021 Changes on a, b, sub, in_valid outside the accept cycle SHALL NOT affect the result in flight.
REQ-022 carry_out SHALL equal the final carry register (for sub, 1 means no borrow).
REQ-023 overflow SHALL equal (A[MSB]==b_eff[MSB]) && (sum[MSB]!=A[MSB]).
REQ-024 out_ready asserted while not in DONE SHALL be ignored.
REQ-025 WIDTH==CHUNK SHALL be legal: RUN lasts one cycle.
REQ-026 sum, carry_out, overflow SHALL be registered outputs; no combinational path from inputs to outputs except none.

Reset
REQ-027 rst_n low SHALL force IDLE, in_ready=1 after release, out_valid=0, sum=0, carry_out=0, overflow=0, carry register and index=0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation; no result SHALL be presented afterwards.

Structure
REQ-029 An adder_pkg package SHALL hold the FSM state typedef (IDLE, RUN, DONE).
REQ-030 One sub-module chunk_cla SHALL implement a CHUNK-bit carry-lookahead slice (a, b, cin -> s, cout), instantiated once and reused each RUN cycle.
REQ-031 Index counter SHALL be $clog2(NCHUNK) bits wide, minimum 1.

Verification
REQ-032 Default params, A=32'h7fffffff, B=32'h1, sub=0 -> out_valid 4 cycles after accept, sum=32'h80000000, carry_out=0, overflow=1.
REQ-033 A=32'hffffffff, B=32'h80000000, sub=0 -> sum=32'h7fffffff, carry_out=1, overflow=1.
REQ-034 A=32'h2, B=32'h5, sub=1 -> sum=32'hfffffffd, carry_out=0, overflow=0; A=32'hc, B=32'h19, sub=0 -> sum=32'h25, carry_out=0, overflow=0.
REQ-035 out_ready held 0 for 5 cycles in DONE while a/b toggle -> out_valid and sum stay constant, in_ready=0; release -> IDLE next cycle.
REQ-036 rst_n pulsed low at RUN cycle 2 -> out_valid never asserts for that operation, all outputs 0, in_ready=1 after release.
REQ-037 WIDTH=16, CHUNK=16, A=16'h0007, B=16'h0008 -> out_valid 1 cycle after accept, sum=16'h000f, carry_out=0, overflow=0.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked sequential adder.
// No logic; latency n/a.
// No flow control; consumed by seq_chunk_adder.
package adder_pkg;

    // Operation phases: waiting for operands, adding chunks, holding result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the chunk index counter; a single chunk still needs one bit.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_cla.sv
// CHUNK-bit carry-lookahead adder slice: s = a + b + cin, cout = carry out.
// Latency: purely combinational.
// Backpressure: none.
module chunk_cla #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
);

    logic [CHUNK-1:0] w_p;
    logic [CHUNK-1:0] w_g;
    logic [CHUNK:0]   w_c;
    logic             w_term;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Every carry is a flat sum of generate terms propagated through the
    // bits above them, plus cin propagated through all lower bits.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        for (int i = 0; i <= CHUNK; i++) begin
            w_term = cin;
            for (int j = 0; j < i; j++) begin
                w_term = w_term & w_p[j];
            end
            w_c[i] = w_term;
            for (int j = 0; j < i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k < i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[i] = w_c[i] | w_term;
            end
        end
    end

    assign s    = w_p ^ w_c[CHUNK-1:0];
    assign cout = w_c[CHUNK];

endmodule

// File: rtl/seq_chunk_adder.sv
// Sequential add/subtract, CHUNK bits per cycle through one shared CLA slice.
// Latency: result valid WIDTH/CHUNK cycles after the accept edge.
// Backpressure: result held in DONE until out_ready; no accept while busy.
module seq_chunk_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    import adder_pkg::*;

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = idx_width(NCHUNK);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;       // operand B already inverted for subtract
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_sum;
    logic             r_co;
    logic             r_ov;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK-1:0] w_s;
    logic             w_cout;

    assign w_last    = (r_idx == LAST_IDX);
    assign w_a_chunk = r_a[CHUNK*int'(r_idx) +: CHUNK];
    assign w_b_chunk = r_b[CHUNK*int'(r_idx) +: CHUNK];

    chunk_cla #(
        .CHUNK (CHUNK)
    ) u_cla (
        .a    (w_a_chunk),
        .b    (w_b_chunk),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs, decoded from the current state only.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        w_accept  = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath: capture operands on accept, then fold in one chunk per RUN
    // cycle; the final chunk also latches carry and signed overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
            r_co    <= 1'b0;
            r_ov    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
        end else if (r_state == RUN) begin
            r_sum[CHUNK*int'(r_idx) +: CHUNK] <= w_s;
            r_carry <= w_cout;
            if (w_last) begin
                r_idx <= '0;
                r_co  <= w_cout;
                r_ov  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) &&
                         (w_s[CHUNK-1] != r_a[WIDTH-1]);
            end else begin
                r_idx <= r_idx + IDXW'(1);
            end
        end
    end

    assign sum       = r_sum;
    assign carry_out = r_co;
    assign overflow  = r_ov;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (32/8 and single-chunk 16/16).
// Latency and throughput checked against cycle counts.
// Backpressure exercised by holding out_ready low in DONE.
module tb_seq_chunk_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow;
    logic [31:0] a, b, sum;
    logic        in_valid16, in_ready16, sub16, out_valid16, out_ready16, carry_out16, overflow16;
    logic [15:0] a16, b16, sum16;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    seq_chunk_adder #(.WIDTH(32), .CHUNK(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out), .overflow(overflow)
    );

    seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .sub(sub16), .out_valid(out_valid16), .out_ready(out_ready16),
        .sum(sum16), .carry_out(carry_out16), .overflow(overflow16)
    );

    // Reference: true integer add/subtract; carry is unsigned carry (or
    // no-borrow), overflow is "signed result not representable in w bits".
    task automatic model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                         input logic isub, output logic [31:0] es,
                         output logic eco, output logic eov);
        longint half, full, ua, ub, sa, sb, ur, sr;
        half = longint'(1) << (w - 1);
        full = half << 1;
        ua = longint'(ia) & (full - 1);
        ub = longint'(ib) & (full - 1);
        sa = (ua >= half) ? ua - full : ua;
        sb = (ub >= half) ? ub - full : ub;
        if (isub) begin
            ur  = ua - ub;
            eco = (ua >= ub);
            sr  = sa - sb;
        end else begin
            ur  = ua + ub;
            eco = (ur >= full);
            sr  = sa + sb;
        end
        es  = 32'(ur & (full - 1));
        eov = (sr >= half) || (sr < -half);
    endtask

    // Present an operation and wait (bounded) for the accept edge; then
    // scramble the operand inputs so they cannot leak into the result.
    task automatic start_op(input logic [31:0] ia, input logic [31:0] ib,
                            input logic isub, output bit ok);
        int n;
        n = 0;
        a = ia; b = ib; sub = isub; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        ok = in_ready;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
    endtask

    // Wait (bounded) for out_valid, counting cycles since the accept edge.
    // Inputs and out_ready toggle meanwhile; none of it may matter.
    task automatic wait_done(output int lat, output bit ok);
        lat = 0;
        while (!out_valid && lat < 50) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1; lat++;
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        ok = out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || sum !== 32'h0) begin
            n_fail++; $display("FAIL reset_hold: out_valid=%b sum=%h expected 0/0", out_valid, sum);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if ({sum, carry_out, overflow} !== 34'h0) begin
            n_fail++; $display("FAIL reset_outputs: sum=%h co=%b ov=%b expected 0", sum, carry_out, overflow);
        end
        n_checks++;
        if (in_ready16 !== 1'b1 || out_valid16 !== 1'b0 || sum16 !== 16'h0) begin
            n_fail++; $display("FAIL reset_dut16: in_ready=%b out_valid=%b sum=%h expected 1/0/0",
                               in_ready16, out_valid16, sum16);
        end
    endtask

    task automatic test_directed();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vs [4];
        logic [31:0] xs [4];
        logic        xc [4];
        logic        xo [4];
        int lat;
        bit ok1, ok2;
        va = '{32'h7fffffff, 32'hffffffff, 32'h2,        32'hc};
        vb = '{32'h1,        32'h80000000, 32'h5,        32'h19};
        vs = '{1'b0,         1'b0,         1'b1,         1'b0};
        xs = '{32'h80000000, 32'h7fffffff, 32'hfffffffd, 32'h25};
        xc = '{1'b0,         1'b1,         1'b0,         1'b0};
        xo = '{1'b1,         1'b1,         1'b0,         1'b0};
        for (int i = 0; i < 4; i++) begin
            start_op(va[i], vb[i], vs[i], ok1);
            wait_done(lat, ok2);
            n_checks++;
            if (!(ok1 && ok2) || lat != 4) begin
                n_fail++; $display("FAIL dir%0d_latency: got %0d cycles (ok=%b%b) expected 4", i, lat, ok1, ok2);
            end
            n_checks++;
            if (sum !== xs[i] || carry_out !== xc[i] || overflow !== xo[i]) begin
                n_fail++; $display("FAIL dir%0d_result: got sum=%h co=%b ov=%b expected %h/%b/%b",
                                   i, sum, carry_out, overflow, xs[i], xc[i], xo[i]);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            n_checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_release: out_valid=%b in_ready=%b expected 0/1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ia, ib, es;
        logic        is, eco, eov;
        int lat;
        bit ok1, ok2;
        ia = $urandom; ib = $urandom; is = 1'($urandom_range(0, 1));
        model(32, ia, ib, is, es, eco, eov);
        start_op(ia, ib, is, ok1);
        wait_done(lat, ok2);
        n_checks++;
        if (!(ok1 && ok2)) begin
            n_fail++; $display("FAIL bp_handshake: accept=%b done=%b expected 1/1", ok1, ok2);
        end
        for (int k = 0; k < 5; k++) begin
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es ||
                carry_out !== eco || overflow !== eov) begin
                n_fail++; $display("FAIL bp_hold%0d: vld=%b rdy=%b sum=%h co=%b ov=%b expected 1/0/%h/%b/%b",
                                   k, out_valid, in_ready, sum, carry_out, overflow, es, eco, eov);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_abort();
        bit ok, seen;
        start_op(32'h12345678, 32'h9abcdef0, 1'b0, ok);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {sum, carry_out, overflow} !== 34'h0) begin
            n_fail++; $display("FAIL abort_in_reset: vld=%b rdy=%b sum=%h co=%b ov=%b expected 0/1/0/0/0",
                               out_valid, in_ready, sum, carry_out, overflow);
        end
        #2;
        rst_n = 1'b1;
        seen = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        n_checks++;
        if (seen !== 1'b0 || !ok) begin
            n_fail++; $display("FAIL abort_no_result: out_valid seen=%b (accept ok=%b) expected 0", seen, ok);
        end
        n_checks++;
        if (in_ready !== 1'b1 || {sum, carry_out, overflow} !== 34'h0) begin
            n_fail++; $display("FAIL abort_after: in_ready=%b sum=%h co=%b ov=%b expected 1/0/0/0",
                               in_ready, sum, carry_out, overflow);
        end
    endtask

    task automatic test_back_to_back();
        int t [3];
        int n;
        logic [31:0] ia, ib, es;
        logic        is, eco, eov;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ia = $urandom; ib = $urandom; is = 1'($urandom_range(0, 1));
            model(32, ia, ib, is, es, eco, eov);
            a = ia; b = ib; sub = is;
            n = 0;
            while (!in_ready && n < 50) begin
                @(posedge clk); #1; n++;
            end
            t[k] = cyc;
            @(posedge clk); #1;
            a = $urandom; b = $urandom; sub = 1'($urandom_range(0, 1));
            n = 0;
            while (!out_valid && n < 50) begin
                @(posedge clk); #1; n++;
            end
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== es ||
                carry_out !== eco || overflow !== eov) begin
                n_fail++; $display("FAIL b2b%0d_result: vld=%b rdy=%b sum=%h co=%b ov=%b expected 1/0/%h/%b/%b",
                                   k, out_valid, in_ready, sum, carry_out, overflow, es, eco, eov);
            end
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k < 3; k++) begin
            n_checks++;
            if (t[k] - t[k-1] != 6) begin
                n_fail++; $display("FAIL b2b%0d_period: got %0d cycles expected 6", k, t[k] - t[k-1]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] ia, ib, es;
        logic        is, eco, eov;
        logic [31:0] edges [4];
        int lat, hold;
        bit ok1, ok2;
        edges = '{32'h80000000, 32'hffffffff, 32'h7fffffff, 32'h00000000};
        for (int i = 0; i < 30; i++) begin
            ia = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            ib = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : $urandom;
            is = 1'($urandom_range(0, 1));
            model(32, ia, ib, is, es, eco, eov);
            start_op(ia, ib, is, ok1);
            wait_done(lat, ok2);
            n_checks++;
            if (!(ok1 && ok2) || lat != 4 || sum !== es || carry_out !== eco || overflow !== eov) begin
                n_fail++; $display("FAIL rnd%0d: %h %s %h got lat=%0d sum=%h co=%b ov=%b expected 4/%h/%b/%b",
                                   i, ia, is ? "-" : "+", ib, lat, sum, carry_out, overflow, es, eco, eov);
            end
            hold = $urandom_range(0, 3);
            repeat (hold) begin
                @(posedge clk); #1;
            end
            n_checks++;
            if (out_valid !== 1'b1 || sum !== es) begin
                n_fail++; $display("FAIL rnd%0d_hold: vld=%b sum=%h expected 1/%h", i, out_valid, sum, es);
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    task automatic test_single_chunk();
        logic [31:0] ia, ib, es;
        logic        is, eco, eov;
        int n;
        for (int i = 0; i < 8; i++) begin
            if (i == 0) begin
                ia = 32'h7; ib = 32'h8; is = 1'b0;
            end else begin
                ia = {16'h0, 16'($urandom)}; ib = {16'h0, 16'($urandom)};
                is = 1'($urandom_range(0, 1));
            end
            model(16, ia, ib, is, es, eco, eov);
            a16 = ia[15:0]; b16 = ib[15:0]; sub16 = is; in_valid16 = 1'b1;
            n = 0;
            while (!in_ready16 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            @(posedge clk); #1;
            in_valid16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
            n = 0;
            while (!out_valid16 && n < 50) begin
                @(posedge clk); #1; n++;
            end
            n_checks++;
            if (out_valid16 !== 1'b1 || n != 1 || sum16 !== es[15:0] ||
                carry_out16 !== eco || overflow16 !== eov) begin
                n_fail++; $display("FAIL w16_%0d: got lat=%0d sum=%h co=%b ov=%b expected 1/%h/%b/%b",
                                   i, n, sum16, carry_out16, overflow16, es[15:0], eco, eov);
            end
            out_ready16 = 1'b1;
            @(posedge clk); #1;
            out_ready16 = 1'b0;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; out_ready16 = 1'b0;
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        test_random();
        test_single_chunk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
